// File: rtl/univ_shift_reg.sv
// WIDTH-bit operand register with parallel load and a bit-serial shift/rotate engine
// that performs one single-bit shift per clock under a start/busy/done handshake.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [2:0]       mode_l;
  logic             fill_l;

  logic [WIDTH-1:0] shift_data;
  logic             shift_out;

  // Single-bit result of the latched operation; reserved modes leave data and serial_out alone.
  always_comb begin
    shift_data = data;
    shift_out  = serial_out;
    case (mode_l)
      3'b000: begin
        shift_data = {data[WIDTH-2:0], fill_l};
        shift_out  = data[WIDTH-1];
      end
      3'b001: begin
        shift_data = {fill_l, data[WIDTH-1:1]};
        shift_out  = data[0];
      end
      3'b010: begin
        shift_data = {data[WIDTH-2:0], data[WIDTH-1]};
        shift_out  = data[WIDTH-1];
      end
      3'b011: begin
        shift_data = {data[0], data[WIDTH-1:1]};
        shift_out  = data[0];
      end
      3'b100: begin
        shift_data = {data[WIDTH-1], data[WIDTH-1:1]};
        shift_out  = data[0];
      end
      3'b101: begin
        shift_data = {data[WIDTH-2:0], 1'b0};
        shift_out  = data[WIDTH-1];
      end
      default: begin
        shift_data = data;
        shift_out  = serial_out;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      data       <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      mode_l     <= 3'b000;
      fill_l     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (load) begin
            data <= data_in;
          end else if (start) begin
            if (amount == '0) begin
              done <= 1'b1;
            end else begin
              state  <= StShift;
              busy   <= 1'b1;
              count  <= amount;
              mode_l <= mode;
              fill_l <= serial_in;
            end
          end
        end
        StShift: begin
          if (load) begin
            // Abort: take the new value and return to idle without a done pulse.
            data  <= data_in;
            state <= StIdle;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            data       <= shift_data;
            serial_out <= shift_out;
            count      <= count - 1'b1;
            if (count == CNT_W'(1)) begin
              state <= StIdle;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized self-checking bench for univ_shift_reg against a cycle-level behavioural model.
module tb_univ_shift_reg;

  localparam int unsigned W = 8;
  localparam int unsigned CW = 4;

  logic          Clk;
  logic          reset;
  logic          load;
  logic [W-1:0]  data_in;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amount;
  logic          serial_in;
  logic [W-1:0]  data;
  logic          serial_out;
  logic          busy;
  logic          done;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .start      (start),
    .mode       (mode),
    .amount     (amount),
    .serial_in  (serial_in),
    .data       (data),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_data;
  logic         m_so;
  logic         m_busy;
  logic         m_done;
  int           m_left;
  logic [2:0]   m_mode;
  logic         m_fill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    m_mode = 3'b000; m_fill = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [W-1:0] din, input logic st,
                            input logic [2:0] md, input logic [CW-1:0] amt, input logic si);
    logic next_done;
    next_done = 1'b0;
    if (!m_busy) begin
      if (ld) m_data = din;
      else if (st) begin
        if (amt == 0) next_done = 1'b1;
        else begin
          m_busy = 1'b1; m_left = int'(amt); m_mode = md; m_fill = si;
        end
      end
    end else if (ld) begin
      m_data = din;
      m_busy = 1'b0;
      m_left = 0;
    end else begin
      case (m_mode)
        3'd0: begin m_so = m_data[W-1]; m_data = (m_data << 1) | W'(m_fill); end
        3'd1: begin m_so = m_data[0]; m_data = (m_data >> 1) | (W'(m_fill) << (W-1)); end
        3'd2: begin m_so = m_data[W-1]; m_data = (m_data << 1) | (m_data >> (W-1)); end
        3'd3: begin m_so = m_data[0]; m_data = (m_data >> 1) | (m_data << (W-1)); end
        3'd4: begin m_so = m_data[0]; m_data = W'($signed(m_data) >>> 1); end
        3'd5: begin m_so = m_data[W-1]; m_data = m_data << 1; end
        default: ;
      endcase
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        next_done = 1'b1;
      end
    end
    m_done = next_done;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".data"}, 32'(data), 32'(m_data));
    check({tag, ".serial_out"}, 32'(serial_out), 32'(m_so));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // One clock with the given inputs, then model update and full comparison.
  task automatic step(input string tag, input logic ld, input logic [W-1:0] din,
                      input logic st, input logic [2:0] md, input logic [CW-1:0] amt,
                      input logic si);
    @(negedge Clk);
    load = ld; data_in = din; start = st; mode = md; amount = amt; serial_in = si;
    @(posedge Clk);
    #1;
    model_edge(ld, din, st, md, amt, si);
    compare_all(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 3'b000, 4'd0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    @(negedge Clk);
    load = 1'b0; start = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge Clk);
    #1;
    compare_all({tag, ".held"});
    @(negedge Clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; data_in = '0; start = 1'b0; mode = '0; amount = '0;
    serial_in = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge Clk);
    reset = 1'b1;

    step("load_d3", 1'b1, 8'hD3, 1'b0, 3'b000, 4'd0, 1'b0);
    check("load_d3.value", 32'(data), 32'h0000_00D3);

    step("rol_start", 1'b0, 8'h00, 1'b1, 3'b010, 4'd3, 1'b0);
    idle_step("rol_1");
    check("rol_1.value", 32'(data), 32'h0000_00A7);
    idle_step("rol_2");
    check("rol_2.value", 32'(data), 32'h0000_004F);
    idle_step("rol_3");
    check("rol_3.value", 32'(data), 32'h0000_009E);
    check("rol_3.done", 32'(done), 32'd1);
    idle_step("rol_after");

    step("asr_load", 1'b1, 8'h81, 1'b0, 3'b000, 4'd0, 1'b0);
    step("asr_start", 1'b0, 8'h00, 1'b1, 3'b100, 4'd2, 1'b0);
    step("asr_1", 1'b0, 8'h00, 1'b1, 3'b000, 4'd7, 1'b1);
    check("asr_1.value", 32'(data), 32'h0000_00C0);
    idle_step("asr_2");
    check("asr_2.value", 32'(data), 32'h0000_00E0);
    check("asr_2.serial_out", 32'(serial_out), 32'd0);
    idle_step("asr_after");

    step("ror_load", 1'b1, 8'hAA, 1'b0, 3'b000, 4'd0, 1'b0);
    step("ror_start", 1'b0, 8'h00, 1'b1, 3'b011, 4'd8, 1'b0);
    for (int i = 0; i < 8; i++) idle_step("ror_run");
    check("ror8.value", 32'(data), 32'h0000_00AA);
    step("amt0", 1'b0, 8'h00, 1'b1, 3'b001, 4'd0, 1'b1);
    check("amt0.busy", 32'(busy), 32'd0);
    check("amt0.done", 32'(done), 32'd1);
    idle_step("amt0_after");

    step("abort_load0", 1'b1, 8'h00, 1'b0, 3'b000, 4'd0, 1'b0);
    step("abort_start", 1'b0, 8'h00, 1'b1, 3'b001, 4'd5, 1'b1);
    idle_step("abort_sh1");
    step("abort_ld", 1'b1, 8'h3C, 1'b0, 3'b000, 4'd0, 1'b0);
    check("abort_ld.value", 32'(data), 32'h0000_003C);
    idle_step("abort_ld_after");
    check("abort_ld.nodone", 32'(done), 32'd0);
    step("rst_start", 1'b0, 8'h00, 1'b1, 3'b001, 4'd5, 1'b1);
    idle_step("rst_sh1");
    idle_step("rst_sh2");
    async_reset("abort_rst");
    idle_step("abort_rst_after");

    for (int n = 0; n < 3000; n++) begin
      logic          r_ld;
      logic          r_st;
      logic [CW-1:0] r_amt;
      r_ld  = ($urandom_range(0, 19) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_amt = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                          : CW'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      step("rand", r_ld, W'($urandom), r_st, 3'($urandom), r_amt, 1'($urandom));
      check("rand.excl", 32'(busy & done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
